// File: rtl/csr_cnt_pkg.sv
// Shared constants for the counter/CSR unit: address map, CSR op encoding,
// counter index layout and the mcountinhibit implemented-bit mask.
package csr_cnt_pkg;

    typedef enum logic [1:0] {
        CSR_READ  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] ADDR_MCOUNTEROVF   = 12'h7C0;

    localparam int IDX_CY       = 0;
    localparam int IDX_IR       = 2;
    localparam int IDX_HPM_BASE = 3;

    // Slice i holds cycle (0), instret (1) or HPM i-2; its inhibit bit skips
    // the unimplemented time slot.
    function automatic int slice_inh_bit(input int i);
        return (i == 0) ? IDX_CY : i + 1;
    endfunction

    function automatic logic [31:0] inhibit_mask(input int num_hpm);
        logic [31:0] m;
        m = '0;
        m[IDX_CY] = 1'b1;
        m[IDX_IR] = 1'b1;
        for (int k = 0; k < num_hpm; k++) m[IDX_HPM_BASE + k] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/cnt_slice.sv
// One CNT_WIDTH-bit counter: half-word writes override the increment, and
// ovf_pulse flags a carry out of an increment that actually commits.
module cnt_slice
    import csr_cnt_pkg::*;
#(
    parameter int CNT_WIDTH = 64,
    parameter int INC_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INC_WIDTH-1:0] inc,
    input  logic                 inhibit,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [31:0]          wdata,
    output logic [CNT_WIDTH-1:0] value,
    output logic                 ovf_pulse
);

    logic [CNT_WIDTH:0] sum;
    logic               bump;
    logic               unused_wdata;

    assign sum          = {1'b0, value} + (CNT_WIDTH+1)'(inc);
    assign bump         = !inhibit && !wr_lo && !wr_hi;
    assign ovf_pulse    = !reset && bump && sum[CNT_WIDTH];
    // wdata bits above the implemented high half are dropped on purpose
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk) begin
        if (reset)
            value <= '0;
        else if (wr_lo)
            value[31:0] <= wdata;
        else if (wr_hi)
            value[CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
        else if (!inhibit)
            value <= sum[CNT_WIDTH-1:0];
    end

endmodule

// File: rtl/csr_counters.sv
// Counter/CSR unit: combinational CSR decode and read mux, mcountinhibit and
// sticky overflow registers, plus one cnt_slice per architectural counter.
module csr_counters
    import csr_cnt_pkg::*;
#(
    parameter int NUM_HPM      = 4,
    parameter int CNT_WIDTH    = 64,
    parameter int RETIRE_WIDTH = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [$clog2(RETIRE_WIDTH+1)-1:0]       retire_cnt,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
    input  logic                                    csr_valid,
    input  logic [11:0]                             csr_addr,
    input  logic [1:0]                              csr_op,
    input  logic [31:0]                             csr_wdata,
    output logic [31:0]                             csr_rdata,
    output logic                                    csr_hit,
    output logic                                    csr_illegal,
    output logic [NUM_HPM+1:0]                      ovf
);

    localparam int          NCNT     = 2 + NUM_HPM;
    localparam int          INC_W    = $clog2(RETIRE_WIDTH+1);
    localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

    logic [NCNT-1:0][CNT_WIDTH-1:0] cnt_val;
    logic [NCNT-1:0][INC_W-1:0]     cnt_inc;
    logic [NCNT-1:0]                cnt_inh;
    logic [NCNT-1:0]                cnt_wr_lo;
    logic [NCNT-1:0]                cnt_wr_hi;
    logic [NCNT-1:0]                cnt_ovf;
    logic [31:0]                    mcountinhibit;

    logic        is_user, is_mach, is_hi;
    logic        ctr_hit, inh_hit, ovf_hit, hit;
    logic [4:0]  off, ctr_idx;
    logic [63:0] ext;
    logic [31:0] old, wval;
    logic        wr_en, do_wr;
    logic        unused_hpm;

    assign unused_hpm = ^hpm_event;

    // Address decode and pre-edge read value
    always_comb begin
        is_user = csr_addr[11:8] == ADDR_CYCLE[11:8];
        is_mach = csr_addr[11:8] == ADDR_MCYCLE[11:8];
        is_hi   = csr_addr[7];
        off     = csr_addr[4:0];
        ctr_hit = 1'b0;
        ctr_idx = '0;
        if ((is_user || is_mach) && csr_addr[6:5] == 2'b00) begin
            if (int'(off) == IDX_CY) begin
                ctr_hit = 1'b1;
            end else if (int'(off) >= IDX_IR && int'(off) < IDX_HPM_BASE + NUM_HPM) begin
                // instret and HPM counters pack densely after cycle
                ctr_hit = 1'b1;
                ctr_idx = off - 5'd1;
            end
        end
        inh_hit = csr_addr == ADDR_MCOUNTINHIBIT;
        ovf_hit = csr_addr == ADDR_MCOUNTEROVF;
        hit     = ctr_hit || inh_hit || ovf_hit;

        old = '0;
        ext = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (ctr_hit && int'(ctr_idx) == i) begin
                ext = 64'(cnt_val[i]);
                old = is_hi ? ext[63:32] : ext[31:0];
            end
        end
        if (inh_hit) old = mcountinhibit;
        if (ovf_hit) old = 32'(ovf);
    end

    // Effective write: set/clear with a zero mask is a pure read
    always_comb begin
        wr_en = 1'b0;
        wval  = old;
        case (csr_op_e'(csr_op))
            CSR_WRITE: begin
                wr_en = 1'b1;
                wval  = csr_wdata;
            end
            CSR_SET: begin
                wr_en = |csr_wdata;
                wval  = old | csr_wdata;
            end
            CSR_CLEAR: begin
                wr_en = |csr_wdata;
                wval  = old & ~csr_wdata;
            end
            default: ;
        endcase
    end

    assign do_wr       = csr_valid && hit && wr_en && !(ctr_hit && is_user);
    assign csr_illegal = csr_valid && (!hit || (wr_en && ctr_hit && is_user));
    assign csr_hit     = csr_valid && hit;
    assign csr_rdata   = csr_valid ? old : 32'h0;

    always_comb begin
        cnt_inc   = '0;
        cnt_inh   = '0;
        cnt_wr_lo = '0;
        cnt_wr_hi = '0;
        cnt_inc[0] = INC_W'(1);
        cnt_inc[1] = retire_cnt;
        for (int k = 0; k < NUM_HPM; k++) cnt_inc[2+k] = INC_W'(hpm_event[k]);
        for (int i = 0; i < NCNT; i++) begin
            cnt_inh[i]   = mcountinhibit[slice_inh_bit(i)];
            cnt_wr_lo[i] = do_wr && ctr_hit && int'(ctr_idx) == i && !is_hi;
            cnt_wr_hi[i] = do_wr && ctr_hit && int'(ctr_idx) == i && is_hi;
        end
    end

    for (genvar i = 0; i < NCNT; i++) begin : g_cnt
        cnt_slice #(
            .CNT_WIDTH(CNT_WIDTH),
            .INC_WIDTH(INC_W)
        ) u_slice (
            .clk       (clk),
            .reset     (reset),
            .inc       (cnt_inc[i]),
            .inhibit   (cnt_inh[i]),
            .wr_lo     (cnt_wr_lo[i]),
            .wr_hi     (cnt_wr_hi[i]),
            .wdata     (wval),
            .value     (cnt_val[i]),
            .ovf_pulse (cnt_ovf[i])
        );
    end

    // Hardware overflow sets are OR'd in after a software write so they win
    always_ff @(posedge clk) begin
        if (reset) begin
            mcountinhibit <= '0;
            ovf           <= '0;
        end else begin
            if (do_wr && inh_hit)
                mcountinhibit <= wval & INH_MASK;
            if (do_wr && ovf_hit)
                ovf <= wval[NCNT-1:0] | cnt_ovf;
            else
                ovf <= ovf | cnt_ovf;
        end
    end

endmodule

// File: tb/tb_csr_counters.sv
// Directed bench for csr_counters with NUM_HPM=4, CNT_WIDTH=40, RETIRE_WIDTH=2.
module tb_csr_counters;
    import csr_cnt_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  retire_cnt = '0;
    logic [3:0]  hpm_event = '0;
    logic        csr_valid = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        csr_illegal;
    logic [5:0]  ovf;

    int n_cmp = 0;
    int n_err = 0;

    csr_counters #(
        .NUM_HPM(4),
        .CNT_WIDTH(40),
        .RETIRE_WIDTH(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .retire_cnt  (retire_cnt),
        .hpm_event   (hpm_event),
        .csr_valid   (csr_valid),
        .csr_addr    (csr_addr),
        .csr_op      (csr_op),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_hit     (csr_hit),
        .csr_illegal (csr_illegal),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_valid = 1'b1;
        csr_op    = 2'b00;
        csr_addr  = a;
        csr_wdata = '0;
        #1;
        chk(tag, csr_rdata, exp);
        csr_valid = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = d;
        @(posedge clk);
        #1;
        csr_valid = 1'b0;
    endtask

    initial begin
        // reset, then the first post-reset cycle
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rd("rst_cycle", 12'hC00, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rd("rst_inh", 12'h320, 32'h0);
        csr_valid = 1'b0; csr_addr = 12'hB00; #1;
        chk("idle_rdata", csr_rdata, 32'h0);
        chk("idle_hit", 32'(csr_hit), 32'h0);
        chk("idle_illegal", 32'(csr_illegal), 32'h0);
        step();
        rd("cycle_one", 12'hC00, 32'd1);

        // wrap and overflow at 40 bits; wdata above the width is ignored
        wr(12'hB80, 2'b01, 32'h1234_56FF);
        rd("mcycleh_trunc", 12'hC80, 32'hFF);
        wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        rd("mcycle_max", 12'hB00, 32'hFFFF_FFFF);
        chk("ovf_pre_wrap", 32'(ovf), 32'h0);
        step();
        rd("cycle_wrap", 12'hC00, 32'h0);
        rd("cycleh_wrap", 12'hC80, 32'h0);
        chk("ovf_wrap", 32'(ovf), 32'h1);

        // write beats the same-cycle increment
        wr(12'hB00, 2'b01, 32'd100);
        rd("collide_100", 12'hC00, 32'd100);
        step();
        rd("collide_101", 12'hC00, 32'd101);

        // inhibit everything: takes effect the cycle after the write
        wr(12'h320, 2'b01, 32'hFFFF_FFFF);
        rd("inh_mask", 12'h320, 32'h7D);
        rd("inh_cy_a", 12'hC00, 32'd102);
        step();
        rd("inh_cy_b", 12'hC00, 32'd102);
        wr(12'h320, 2'b01, 32'h0);
        rd("inh_cy_c", 12'hC00, 32'd102);
        step();
        rd("inh_cy_resume", 12'hC00, 32'd103);

        // illegal and pure-read accesses
        csr_valid = 1'b1; csr_addr = 12'hC00; csr_op = 2'b01; csr_wdata = 32'd5; #1;
        chk("ill_wr_ro", 32'(csr_illegal), 32'h1);
        chk("ill_wr_ro_hit", 32'(csr_hit), 32'h1);
        csr_valid = 1'b0;
        step();
        rd("ill_no_change", 12'hC00, 32'd104);
        csr_valid = 1'b1; csr_addr = 12'hC00; csr_op = 2'b10; csr_wdata = 32'h0; #1;
        chk("set0_legal", 32'(csr_illegal), 32'h0);
        chk("set0_rdata", csr_rdata, 32'd104);
        csr_wdata = 32'h1; #1;
        chk("set1_ro_ill", 32'(csr_illegal), 32'h1);
        csr_addr = 12'hC1F; csr_op = 2'b00; csr_wdata = 32'h0; #1;
        chk("c1f_hit", 32'(csr_hit), 32'h0);
        chk("c1f_ill", 32'(csr_illegal), 32'h1);
        chk("c1f_rdata", csr_rdata, 32'h0);
        csr_valid = 1'b0;

        // superscalar retire 2,1,0,2
        step();
        retire_cnt = 2'd2; rd("ir_0", 12'hC02, 32'd0); step();
        retire_cnt = 2'd1; rd("ir_2", 12'hC02, 32'd2); step();
        retire_cnt = 2'd0; rd("ir_3a", 12'hC02, 32'd3); step();
        retire_cnt = 2'd2; rd("ir_3b", 12'hC02, 32'd3); step();
        retire_cnt = 2'd0; rd("ir_5", 12'hB02, 32'd5);

        // HPM0 inhibit via csrrs / csrrc
        hpm_event = 4'b0001;
        rd("hpm0_0", 12'hC03, 32'd0);
        wr(12'h320, 2'b10, 32'h8);
        rd("hpm0_1", 12'hC03, 32'd1);
        rd("inh_set8", 12'h320, 32'h8);
        step();
        rd("hpm0_hold", 12'hC03, 32'd1);
        wr(12'h320, 2'b11, 32'h8);
        rd("hpm0_hold2", 12'hC03, 32'd1);
        step();
        rd("hpm0_resume", 12'hB03, 32'd2);
        hpm_event = 4'b0000;
        rd("hpm1_idle", 12'hC04, 32'd0);

        // software clear of mcounterovf loses to a same-cycle HPM1 overflow
        wr(12'hB84, 2'b01, 32'hFF);
        wr(12'hB04, 2'b01, 32'hFFFF_FFFF);
        hpm_event = 4'b0010;
        wr(12'h7C0, 2'b01, 32'h0);
        hpm_event = 4'b0000;
        chk("ovf_hw_wins", 32'(ovf), 32'h08);
        rd("hpm1_wrap", 12'hC04, 32'h0);
        rd("ovf_csr", 12'h7C0, 32'h08);
        wr(12'h7C0, 2'b10, 32'h30);
        chk("ovf_sw_set", 32'(ovf), 32'h38);
        wr(12'h7C0, 2'b01, 32'hFFFF_FFFF);
        rd("ovf_csr_mask", 12'h7C0, 32'h3F);

        // reset mid-run clears counters, inhibit and ovf
        wr(12'h320, 2'b01, 32'h4);
        reset = 1'b1; hpm_event = 4'hF; retire_cnt = 2'd2;
        step();
        reset = 1'b0; hpm_event = 4'h0; retire_cnt = 2'd0;
        rd("mid_rst_cycle", 12'hC00, 32'd0);
        rd("mid_rst_instret", 12'hC02, 32'd0);
        rd("mid_rst_hpm0", 12'hC03, 32'd0);
        rd("mid_rst_inh", 12'h320, 32'h0);
        chk("mid_rst_ovf", 32'(ovf), 32'h0);
        step();
        rd("post_rst_cycle", 12'hC00, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
